// File: rtl/shiftrows_stream.sv
// Streaming AES ShiftRows / InvShiftRows / bypass stage with a valid/ready
// register pipeline, a sideband tag and a completed-block counter.
module shiftrows_stream #(
  parameter int STAGES = 2,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] xfer_count
);

  typedef enum logic [1:0] {
    MODE_FWD     = 2'b00,
    MODE_INV     = 2'b01,
    MODE_BYP     = 2'b10,
    MODE_BYP_ALT = 2'b11
  } mode_e;

  logic [127:0]     w_fwd;
  logic [127:0]     w_inv;
  logic [127:0]     w_perm;
  logic [STAGES-1:0] w_adv;

  logic [STAGES-1:0] r_valid;
  logic [127:0]      r_data [STAGES];
  logic [TAG_W-1:0]  r_tag  [STAGES];
  logic [CNT_W-1:0]  r_count;

  // Byte (r,c) lives at in_data[127-8*(4c+r) -: 8]; both rotations are pure wiring.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign w_fwd[127-8*(4*c+r) -: 8] = in_data[127-8*(4*((c+r)%4)+r) -: 8];
      assign w_inv[127-8*(4*c+r) -: 8] = in_data[127-8*(4*((c-r+4)%4)+r) -: 8];
    end
  end

  // NOTE: every path through this case assigns w_perm (default arm), so no latch is inferred.
  always_comb begin
    case (mode_e'(in_mode))
      MODE_FWD: w_perm = w_fwd;
      MODE_INV: w_perm = w_inv;
      default:  w_perm = in_data;
    endcase
  end

  // A stage may advance if everything downstream of it is full-and-draining or has a hole.
  for (genvar k = 0; k < STAGES; k++) begin : g_adv
    assign w_adv[k] = out_ready | ~(&r_valid[STAGES-1:k]);
  end

  // NOTE: non-blocking assignments so every stage samples its neighbour's pre-edge value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      // NOTE: data and tag are cleared too, so out_data/out_tag read zero after reset.
      for (int k = 0; k < STAGES; k++) begin
        r_data[k] <= '0;
        r_tag[k]  <= '0;
      end
    end else begin
      if (w_adv[0]) begin
        r_valid[0] <= in_valid;
        r_data[0]  <= w_perm;
        r_tag[0]   <= in_tag;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_adv[k]) begin
          r_valid[k] <= r_valid[k-1];
          r_data[k]  <= r_data[k-1];
          r_tag[k]   <= r_tag[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (out_valid && out_ready) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign in_ready   = w_adv[0];
  assign out_valid  = r_valid[STAGES-1];
  assign out_data   = r_data[STAGES-1];
  assign out_tag    = r_tag[STAGES-1];
  assign xfer_count = r_count;

endmodule

// File: tb/tb_shiftrows_stream.sv
// Self-checking bench: three builds (STAGES 2/1/4, CNT_W 32/4/32) share one input
// stream and are each scored against a queue-based ShiftRows model.
module tb_shiftrows_stream;

  localparam int TAG_W = 4;

  typedef struct {
    logic [127:0]     d;
    logic [TAG_W-1:0] t;
  } blk_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             in_valid;
  logic [127:0]     in_data;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic [2:0]       out_ready;
  logic [2:0]       in_ready;
  logic [2:0]       out_valid;
  logic [127:0]     out_data [3];
  logic [TAG_W-1:0] out_tag  [3];
  logic [31:0]      cnt0;
  logic [3:0]       cnt1;
  logic [31:0]      cnt2;
  logic [31:0]      xfer [3];

  assign xfer[0] = cnt0;
  assign xfer[1] = {28'd0, cnt1};
  assign xfer[2] = cnt2;

  shiftrows_stream #(.STAGES(2), .TAG_W(TAG_W), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_data(in_data), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_tag(out_tag[0]), .xfer_count(cnt0));

  shiftrows_stream #(.STAGES(1), .TAG_W(TAG_W), .CNT_W(4)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_data(in_data), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_tag(out_tag[1]), .xfer_count(cnt1));

  shiftrows_stream #(.STAGES(4), .TAG_W(TAG_W), .CNT_W(32)) u_dut_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
    .in_data(in_data), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .out_tag(out_tag[2]), .xfer_count(cnt2));

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input bit ok, input string name,
                       input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int st(input int d);
    case (d)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  // Reference: out(r,c) = in(r,(c+r)%4) forward, in(r,(c-r)%4) inverse, identity otherwise.
  function automatic logic [127:0] model_perm(input logic [127:0] d, input logic [1:0] m);
    logic [7:0]   b [16];
    logic [127:0] o;
    int           sc;
    for (int i = 0; i < 16; i++) b[i] = d[127-8*i -: 8];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (m == 2'b00)      sc = (c + r) % 4;
        else if (m == 2'b01) sc = (c - r + 4) % 4;
        else                 sc = c;
        o[127-8*(4*c+r) -: 8] = b[4*sc+r];
      end
    end
    return o;
  endfunction

  // Model state, one entry per DUT.
  blk_t             sb [3][$];
  logic [31:0]      exp_cnt [3];
  bit               prev_stall [3];
  logic [127:0]     prev_data [3];
  logic [TAG_W-1:0] prev_tag [3];
  bit               prev_rst_low = 1'b0;
  int               run [3];
  int               max_run [3];
  bit               lat_arm [3];
  int               lat_acc [3];
  bit               lat_done [3];
  int               cyc = 0;
  bit               ready_rand = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int d = 0; d < 3; d++) begin
      exp_cnt[d] = '0; prev_stall[d] = 1'b0; run[d] = 0; max_run[d] = 0;
      lat_arm[d] = 1'b0; lat_acc[d] = -1; lat_done[d] = 1'b0;
    end
  end

  // Compare process: runs mid-cycle, decides what the coming edge will transfer.
  always @(negedge clk) begin
    blk_t        b;
    logic [31:0] want_cnt;
    for (int d = 0; d < 3; d++) begin
      if (prev_rst_low) begin
        check(out_valid[d] == 1'b0, $sformatf("reset out_valid[%0d]", d), out_valid[d], 0);
        check(out_data[d] === '0, $sformatf("reset out_data[%0d]", d), out_data[d], 0);
        check(out_tag[d] === '0, $sformatf("reset out_tag[%0d]", d), out_tag[d], 0);
        check(xfer[d] === '0, $sformatf("reset xfer_count[%0d]", d), xfer[d], 0);
        check(in_ready[d] == 1'b1, $sformatf("reset in_ready[%0d]", d), in_ready[d], 1);
      end
      if (!rst_n) begin
        sb[d].delete();
        exp_cnt[d]    = '0;
        prev_stall[d] = 1'b0;
        run[d]        = 0;
      end else begin
        if (prev_stall[d]) begin
          check(out_valid[d] == 1'b1, $sformatf("stall out_valid[%0d]", d), out_valid[d], 1);
          check(out_data[d] === prev_data[d], $sformatf("stall out_data[%0d]", d),
                out_data[d], prev_data[d]);
          check(out_tag[d] === prev_tag[d], $sformatf("stall out_tag[%0d]", d),
                out_tag[d], prev_tag[d]);
        end
        if (out_valid[d]) begin
          if (sb[d].size() == 0) begin
            check(1'b0, $sformatf("unexpected out_valid[%0d]", d), out_data[d], 0);
          end else begin
            check(out_data[d] === sb[d][0].d, $sformatf("out_data[%0d]", d),
                  out_data[d], sb[d][0].d);
            check(out_tag[d] === sb[d][0].t, $sformatf("out_tag[%0d]", d),
                  out_tag[d], sb[d][0].t);
          end
          if (lat_acc[d] >= 0 && !lat_done[d]) begin
            check(cyc - lat_acc[d] == st(d) - 1, $sformatf("latency[%0d]", d),
                  cyc - lat_acc[d], st(d) - 1);
            lat_done[d] = 1'b1;
          end
          run[d]++;
          if (run[d] > max_run[d]) max_run[d] = run[d];
        end else begin
          run[d] = 0;
        end
        want_cnt = (d == 1) ? {28'd0, exp_cnt[d][3:0]} : exp_cnt[d];
        check(xfer[d] === want_cnt, $sformatf("xfer_count[%0d]", d), xfer[d], want_cnt);
        prev_stall[d] = out_valid[d] && !out_ready[d];
        prev_data[d]  = out_data[d];
        prev_tag[d]   = out_tag[d];
        if (out_valid[d] && out_ready[d]) begin
          if (sb[d].size() > 0) void'(sb[d].pop_front());
          exp_cnt[d] = exp_cnt[d] + 1;
        end
        if (in_valid && in_ready[d]) begin
          if (lat_arm[d] && lat_acc[d] < 0 && sb[d].size() == 0) lat_acc[d] = cyc + 1;
          b.d = model_perm(in_data, in_mode);
          b.t = in_tag;
          sb[d].push_back(b);
        end
      end
    end
    prev_rst_low = !rst_n;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_rand) out_ready = 3'($urandom);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // All stimulus tasks start and end at 1 time unit after a rising edge.
  task automatic send(input logic [127:0] d, input logic [1:0] m, input logic [TAG_W-1:0] t);
    bit acc = 1'b0;
    in_valid = 1'b1; in_data = d; in_mode = m; in_tag = t;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready[0];
      @(posedge clk);
      #1;
    end
    if (!acc) check(1'b0, "send timeout", 0, 1);
  endtask

  task automatic wait_out0(output logic [127:0] d, output logic [TAG_W-1:0] t);
    bit got = 1'b0;
    d = '0; t = '0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (out_valid[0] && out_ready[0]) begin
        got = 1'b1; d = out_data[0]; t = out_tag[0];
      end
      @(posedge clk);
      #1;
    end
    if (!got) check(1'b0, "wait_out timeout", 0, 1);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic arm_latency();
    for (int d = 0; d < 3; d++) begin
      lat_arm[d] = 1'b1; lat_acc[d] = -1; lat_done[d] = 1'b0; max_run[d] = 0;
    end
  endtask

  logic [127:0]     vec, got_d, fwd_d;
  logic [TAG_W-1:0] got_t;
  int               acc_n;
  bit               acc, saw;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0; in_tag = '0;
    out_ready = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Model pins against hand-computed vectors.
    vec = 128'h000102030405060708090a0b0c0d0e0f;
    check(model_perm(vec, 2'b00) === 128'h00050a0f04090e03080d02070c01060b, "model fwd",
          model_perm(vec, 2'b00), 128'h00050a0f04090e03080d02070c01060b);
    check(model_perm(vec, 2'b01) === 128'h000d0a0704010e0b0805020f0c090603, "model inv",
          model_perm(vec, 2'b01), 128'h000d0a0704010e0b0805020f0c090603);

    // Forward known-answer, latency and first count.
    arm_latency();
    send(128'h63637c7c7b7bc5c57676c0c07575d2d2, 2'b00, 4'd5);
    in_valid = 1'b0;
    wait_out0(got_d, got_t);
    check(got_d === 128'h637bc0d27b76d27c76757cc57563c5c0, "fwd kat data",
          got_d, 128'h637bc0d27b76d27c76757cc57563c5c0);
    check(got_t === 4'd5, "fwd kat tag", got_t, 5);
    check(cnt0 === 32'd1, "fwd kat count", cnt0, 1);
    check(lat_done[0], "fwd kat latency seen", lat_done[0], 1);
    for (int d = 0; d < 3; d++) lat_arm[d] = 1'b0;

    // All three modes on a counting block, then round trip.
    send(vec, 2'b00, 4'd1); in_valid = 1'b0; wait_out0(got_d, got_t);
    fwd_d = got_d;
    check(got_d === 128'h00050a0f04090e03080d02070c01060b, "mode00 data",
          got_d, 128'h00050a0f04090e03080d02070c01060b);
    send(vec, 2'b01, 4'd2); in_valid = 1'b0; wait_out0(got_d, got_t);
    check(got_d === 128'h000d0a0704010e0b0805020f0c090603, "mode01 data",
          got_d, 128'h000d0a0704010e0b0805020f0c090603);
    send(vec, 2'b10, 4'd3); in_valid = 1'b0; wait_out0(got_d, got_t);
    check(got_d === 128'h000102030405060708090a0b0c0d0e0f, "mode10 data", got_d, vec);
    send(fwd_d, 2'b01, 4'd4); in_valid = 1'b0; wait_out0(got_d, got_t);
    check(got_d === 128'h000102030405060708090a0b0c0d0e0f, "round trip", got_d, vec);
    check(got_t === 4'd4, "round trip tag", got_t, 4);

    // Eight tagged blocks under random backpressure.
    do_reset(1);
    ready_rand = 1'b1;
    for (int i = 0; i < 8; i++)
      send({$urandom, $urandom, $urandom, $urandom}, 2'($urandom), TAG_W'(i));
    in_valid = 1'b0;
    ready_rand = 1'b0;
    out_ready = 3'b111;
    repeat (10) @(posedge clk);
    #1;
    check(cnt0 === 32'd8, "backpressure count", cnt0, 8);
    check(sb[0].size() == 0, "backpressure drained", sb[0].size(), 0);

    // Five stalled cycles: exactly STAGES blocks get in, then in_ready drops.
    out_ready = 3'b000;
    acc_n = 0;
    in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom}; in_mode = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      acc = in_ready[0];
      if (acc) acc_n++;
      @(posedge clk);
      #1;
      if (acc) begin
        in_data = {$urandom, $urandom, $urandom, $urandom}; in_tag = TAG_W'($urandom);
      end
    end
    check(acc_n == 2, "stall accept count", acc_n, 2);
    check(in_ready[0] == 1'b0, "stall in_ready low", in_ready[0], 0);
    out_ready = 3'b111;
    #1;
    check(in_ready[0] == 1'b1, "in_ready follows out_ready", in_ready[0], 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Throughput and latency on all builds; 16 completions wrap the 4-bit counter.
    do_reset(1);
    arm_latency();
    for (int i = 0; i < 16; i++)
      send({$urandom, $urandom, $urandom, $urandom}, 2'($urandom), TAG_W'($urandom));
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check(max_run[d] == 16, $sformatf("throughput run[%0d]", d), max_run[d], 16);
      check(lat_done[d], $sformatf("throughput latency seen[%0d]", d), lat_done[d], 1);
      lat_arm[d] = 1'b0;
    end
    check(cnt0 === 32'd16, "throughput count s2", cnt0, 16);
    check(cnt1 === 4'd0, "count wrap s1", cnt1, 0);
    check(cnt2 === 32'd16, "throughput count s4", cnt2, 16);

    // Reset with two blocks in flight: nothing stale may emerge.
    out_ready = 3'b000;
    send(128'h11111111222222223333333344444444, 2'b00, 4'd9);
    send(128'h55555555666666667777777788888888, 2'b01, 4'd10);
    in_valid = 1'b0;
    check(out_valid[0] == 1'b1, "in flight before reset", out_valid[0], 1);
    do_reset(1);
    out_ready = 3'b111;
    check(out_valid[0] == 1'b0, "mid reset out_valid", out_valid[0], 0);
    check(out_data[0] === '0, "mid reset out_data", out_data[0], 0);
    check(cnt0 === 32'd0, "mid reset count", cnt0, 0);
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      saw |= out_valid[0];
    end
    @(posedge clk);
    #1;
    check(saw == 1'b0, "no stale block", saw, 0);

    // Random traffic with random backpressure on all builds.
    ready_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      acc = in_valid && in_ready[0];
      @(posedge clk);
      #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_mode  = 2'($urandom);
        in_tag   = TAG_W'($urandom);
      end
    end
    in_valid = 1'b0;
    ready_rand = 1'b0;
    out_ready = 3'b111;
    repeat (10) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++)
      check(sb[d].size() == 0, $sformatf("random drained[%0d]", d), sb[d].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
